joystick_hub: RTL and testbench
===============================

// Module: joystick_hub
// PURPOSE
// - Parametrised successor to the single-joystick PIO path: NUM_CH joystick channels behind one host register port.
// - Per channel: edge-triggered sample capture, sticky pending/overrun flags, saturating event counter, one-shot write strobe.
// - Sits between the joystick controllers and the soft-core PIO bridge; feeds one aggregated interrupt to the CPU.
// PARAMETERS
// - NUM_CH  default 8   number of joystick channels (1..16)
// - DATA_W  default 64  sample/write data width per channel (msb:lsb joined)
// - CNT_W   default 16  event counter width per channel
// - SEL_W   default 4   host channel-select width; must satisfy 2**SEL_W >= NUM_CH
// PORTS
// - clk_clk                     in   1             system clock, all logic on rising edge
// - reset_reset                 in   1             synchronous reset, active-high
// - irq_joystick_export         in   NUM_CH        raw per-channel data-ready lines (asynchronous)
// - rd_joystick_data            in   NUM_CH*DATA_W per-channel sample buses; channel i at [i*DATA_W +: DATA_W]
// - host_sel                    in   SEL_W         channel select for rd/wr/count/clear
// - host_rd                     in   1             read strobe, 1 cycle
// - host_wr                     in   1             write strobe, 1 cycle
// - host_wdata                  in   DATA_W        write data
// - host_clr_ovr                in   1             clears overrun[host_sel]
// - reset_pulsecounter_export   in   1             clears all event counters
// - host_rdata                  out  DATA_W        captured sample of read channel
// - host_rvalid                 out  1             host_rdata valid, 1 cycle
// - host_count                  out  CNT_W         event counter of host_sel (registered)
// - host_rts                    out  32            capture timestamp of read channel (see CONFIGURATION)
// - irq_pending                 out  NUM_CH        per-channel pending flags
// - irq_overrun                 out  NUM_CH        per-channel sticky overrun flags
// - irq_out                     out  1             OR of irq_pending, registered
// - we_joystick_export          out  NUM_CH        per-channel write strobe, 1 cycle
// - we_joystick_data            out  DATA_W        data accompanying we_joystick_export
// BEHAVIOUR
// - Reset: every output, shadow, counter, flag and sync flop = 0; reset mid-operation drops any in-flight read/write.
// - Input sync: irq_joystick_export through 2-flop synchroniser + 1 history flop; rising edge = sync & ~hist.
// - Edge on ch i (cycle E): shadow[i] <= rd_joystick_data slice i; pending[i] <= 1; count[i] +1, saturating at all-ones.
// - Edge while pending[i] already 1: overrun[i] <= 1, shadow overwritten (latest sample wins).
// - Edge latency: raw line rise to irq_pending[i] = 3 cycles; irq_out one cycle after irq_pending.
// - Read: host_rd at cycle R -> cycle R+1: host_rvalid=1, host_rdata=shadow[sel] as held at R, host_rts likewise;
//   pending[sel] cleared at R+1. host_rdata holds value until next read.
// - Read and edge on same channel in same cycle: rdata returns old shadow; new capture stored; pending stays 1.
// - Write: host_wr at cycle W -> W+1: we_joystick_export[sel]=1 for exactly one cycle, we_joystick_data=host_wdata
//   (data held until next write). host_rd and host_wr together: both executed independently.
// - host_sel >= NUM_CH: read returns rdata=0 with rvalid=1, no flag change; write produces no strobe; host_count=0.
// - host_clr_ovr: overrun[sel] <= 0 next cycle; coincident overrun-setting edge wins (flag stays 1).
// - reset_pulsecounter_export: all counters <= 0; coincident edge on ch i leaves count[i]=1.
// - host_count registered: reflects count[host_sel] of previous cycle.
// CONFIGURATION
// - Macro JOYHUB_TIMESTAMP_EN defined: free-running 32-bit cycle counter (wraps 0xFFFFFFFF->0, reset to 0);
//   per-channel 32-bit stamp captured with shadow on each edge; host_rts returns it with host_rdata.
// - Not defined: no timestamp counter or stamp registers; host_rts tied to 0.
// TESTING
// - Reset: assert reset_reset 2 cycles with all inputs active -> all outputs 0, irq_out=0.
// - Capture: ch 3 data=0x0123_4567_89AB_CDEF, raise irq bit 3 -> irq_pending=0x08 after 3 cycles, irq_out next;
//   host_rd sel=3 -> rvalid 1 cycle, rdata=0x0123456789ABCDEF, pending=0x00.
// - Overrun: two edges on ch 0 (data 0x11 then 0x22) without read -> irq_overrun=0x01, read returns 0x22, count=2;
//   host_clr_ovr sel=0 -> irq_overrun=0x00.
// - Saturation/clear: CNT_W=4, 17 edges on ch 1 -> host_count=15; pulse reset_pulsecounter_export with edge same cycle -> 1.
// - Write + range: host_wr sel=5 wdata=0xAA -> we_joystick_export=0x20 one cycle, data=0xAA; sel=9 (NUM_CH=8) -> no strobe,
//   read gives rdata=0.
// - Timestamp (JOYHUB_TIMESTAMP_EN): edge ch 2 at stamp 100 -> read host_rts=100; without macro host_rts=0.

Source files
------------

// File: rtl/joystick_hub.sv
// joystick_hub: NUM_CH joystick channels behind one host register port.
// Per channel: synchronised edge detect, sample shadow, sticky pending/overrun,
// saturating event counter and a one-shot write strobe. irq_out is the
// registered OR of all pending flags.
// Optional feature macro: JOYHUB_TIMESTAMP_EN (32-bit capture timestamps on host_rts).
// Ports:
//   clk_clk, reset_reset       clock, synchronous active-high reset
//   irq_joystick_export        raw per-channel data-ready lines (async)
//   rd_joystick_data           per-channel sample buses, channel i at [i*DATA_W +: DATA_W]
//   host_sel/rd/wr/wdata       host access: select, read strobe, write strobe, write data
//   host_clr_ovr               clears overrun of the selected channel
//   reset_pulsecounter_export  clears all event counters
//   host_rdata/rvalid/rts      read response (sample, valid, timestamp)
//   host_count                 event counter of host_sel, one cycle late
//   irq_pending/overrun/out    interrupt flags
//   we_joystick_export/data    per-channel write strobe and its data
module joystick_hub #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [NUM_CH-1:0]        irq_joystick_export,
  input  logic [NUM_CH*DATA_W-1:0] rd_joystick_data,
  input  logic [SEL_W-1:0]         host_sel,
  input  logic                     host_rd,
  input  logic                     host_wr,
  input  logic [DATA_W-1:0]        host_wdata,
  input  logic                     host_clr_ovr,
  input  logic                     reset_pulsecounter_export,
  output logic [DATA_W-1:0]        host_rdata,
  output logic                     host_rvalid,
  output logic [CNT_W-1:0]         host_count,
  output logic [31:0]              host_rts,
  output logic [NUM_CH-1:0]        irq_pending,
  output logic [NUM_CH-1:0]        irq_overrun,
  output logic                     irq_out,
  output logic [NUM_CH-1:0]        we_joystick_export,
  output logic [DATA_W-1:0]        we_joystick_data
);

  localparam int unsigned TS_W = 32;

  logic [NUM_CH-1:0] r_sync1, r_sync2, r_hist;
  logic [NUM_CH-1:0] r_pending, r_overrun, r_we;
  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [CNT_W-1:0]  r_count  [NUM_CH];
  logic [DATA_W-1:0] r_rdata, r_we_data;
  logic [CNT_W-1:0]  r_host_count;
  logic [TS_W-1:0]   r_rts;
  logic              r_rvalid, r_irq_out;

  logic [NUM_CH-1:0] w_edge, w_sel_oh;
  logic [DATA_W-1:0] w_rd_shadow;
  logic [CNT_W-1:0]  w_sel_count;
  logic [TS_W-1:0]   w_rd_stamp;

`ifdef JOYHUB_TIMESTAMP_EN
  logic [TS_W-1:0]   r_ts;
  logic [TS_W-1:0]   r_stamp [NUM_CH];
`endif

  // Edge detect and host-select decode; an out-of-range select gives an empty one-hot,
  // so every mux below naturally returns 0 and no per-channel action fires.
  always_comb begin
    w_edge      = r_sync2 & ~r_hist;
    w_sel_oh    = '0;
    w_rd_shadow = '0;
    w_sel_count = '0;
    w_rd_stamp  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel_oh[i] = (host_sel == SEL_W'(i));
      if (w_sel_oh[i]) begin
        w_rd_shadow = r_shadow[i];
        w_sel_count = r_count[i];
`ifdef JOYHUB_TIMESTAMP_EN
        w_rd_stamp  = r_stamp[i];
`endif
      end
    end
  end

  // Host-side response registers and synchroniser chain
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_hist       <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
      r_rts        <= '0;
      r_we         <= '0;
      r_we_data    <= '0;
      r_host_count <= '0;
      r_irq_out    <= 1'b0;
    end else begin
      r_sync1      <= irq_joystick_export;
      r_sync2      <= r_sync1;
      r_hist       <= r_sync2;
      r_rvalid     <= host_rd;
      r_we         <= host_wr ? w_sel_oh : '0;
      r_host_count <= w_sel_count;
      r_irq_out    <= |r_pending;
      if (host_rd) begin
        r_rdata <= w_rd_shadow;
        r_rts   <= w_rd_stamp;
      end
      if (host_wr) r_we_data <= host_wdata;
    end
  end

  // Per-channel capture, flags and counters; a coincident edge always wins over clears
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_pending <= '0;
      r_overrun <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_shadow[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_edge[i]) begin
          r_shadow[i]  <= rd_joystick_data[i*DATA_W +: DATA_W];
          r_pending[i] <= 1'b1;
        end else if (host_rd && w_sel_oh[i]) begin
          r_pending[i] <= 1'b0;
        end
        if (w_edge[i] && r_pending[i]) r_overrun[i] <= 1'b1;
        else if (host_clr_ovr && w_sel_oh[i]) r_overrun[i] <= 1'b0;
        if (reset_pulsecounter_export) r_count[i] <= w_edge[i] ? CNT_W'(1) : '0;
        else if (w_edge[i] && !(&r_count[i])) r_count[i] <= r_count[i] + CNT_W'(1);
      end
    end
  end

`ifdef JOYHUB_TIMESTAMP_EN
  // Free-running cycle counter; stamps are taken alongside the shadow capture
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_ts <= '0;
      for (int i = 0; i < NUM_CH; i++) r_stamp[i] <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      for (int i = 0; i < NUM_CH; i++)
        if (w_edge[i]) r_stamp[i] <= r_ts;
    end
  end
`endif

  assign host_rdata         = r_rdata;
  assign host_rvalid        = r_rvalid;
  assign host_count         = r_host_count;
  assign host_rts           = r_rts;
  assign irq_pending        = r_pending;
  assign irq_overrun        = r_overrun;
  assign irq_out            = r_irq_out;
  assign we_joystick_export = r_we;
  assign we_joystick_data   = r_we_data;

endmodule

// File: tb/tb_joystick_hub.sv
// Directed-vector bench for joystick_hub (NUM_CH=8, DATA_W=64, CNT_W=4, SEL_W=4).
module tb_joystick_hub;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SEL_W  = 4;

  logic                     clk = 1'b0;
  logic                     reset_reset;
  logic [NUM_CH-1:0]        irq_joystick_export;
  logic [NUM_CH*DATA_W-1:0] rd_joystick_data;
  logic [SEL_W-1:0]         host_sel;
  logic                     host_rd, host_wr, host_clr_ovr, reset_pulsecounter_export;
  logic [DATA_W-1:0]        host_wdata;
  logic [DATA_W-1:0]        host_rdata;
  logic                     host_rvalid;
  logic [CNT_W-1:0]         host_count;
  logic [31:0]              host_rts;
  logic [NUM_CH-1:0]        irq_pending, irq_overrun, we_joystick_export;
  logic                     irq_out;
  logic [DATA_W-1:0]        we_joystick_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ts_base;

  joystick_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk_clk                   (clk),
    .reset_reset               (reset_reset),
    .irq_joystick_export       (irq_joystick_export),
    .rd_joystick_data          (rd_joystick_data),
    .host_sel                  (host_sel),
    .host_rd                   (host_rd),
    .host_wr                   (host_wr),
    .host_wdata                (host_wdata),
    .host_clr_ovr              (host_clr_ovr),
    .reset_pulsecounter_export (reset_pulsecounter_export),
    .host_rdata                (host_rdata),
    .host_rvalid               (host_rvalid),
    .host_count                (host_count),
    .host_rts                  (host_rts),
    .irq_pending               (irq_pending),
    .irq_overrun               (irq_overrun),
    .irq_out                   (irq_out),
    .we_joystick_export        (we_joystick_export),
    .we_joystick_data          (we_joystick_data)
  );

  always #5 clk = ~clk;

  // Count of non-reset clock edges, used to predict captured timestamps
  always @(posedge clk) begin
    if (reset_reset) cyc <= 0;
    else             cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clean rising edge on a channel, then the line drops and settles
  task automatic pulse(input int ch, input logic [63:0] d);
    rd_joystick_data[ch*DATA_W +: DATA_W] = d;
    irq_joystick_export[ch] = 1'b1;
    repeat (3) tick();
    irq_joystick_export[ch] = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    // Reset with every input active
    reset_reset = 1'b1;
    irq_joystick_export = '1;
    rd_joystick_data = '1;
    host_sel = 4'd3;
    host_rd = 1'b1;
    host_wr = 1'b1;
    host_wdata = '1;
    host_clr_ovr = 1'b1;
    reset_pulsecounter_export = 1'b1;
    tick();
    tick();
    check("rst_pending", 64'(irq_pending), 64'h0);
    check("rst_overrun", 64'(irq_overrun), 64'h0);
    check("rst_irq_out", 64'(irq_out), 64'h0);
    check("rst_rvalid", 64'(host_rvalid), 64'h0);
    check("rst_rdata", host_rdata, 64'h0);
    check("rst_we", 64'(we_joystick_export), 64'h0);
    check("rst_count", 64'(host_count), 64'h0);
    check("rst_rts", 64'(host_rts), 64'h0);

    irq_joystick_export = '0;
    rd_joystick_data = '0;
    host_rd = 1'b0;
    host_wr = 1'b0;
    host_wdata = '0;
    host_clr_ovr = 1'b0;
    reset_pulsecounter_export = 1'b0;
    reset_reset = 1'b0;
    repeat (3) tick();

    // Capture on channel 3 and latency
    rd_joystick_data[3*DATA_W +: DATA_W] = 64'h0123_4567_89AB_CDEF;
    irq_joystick_export[3] = 1'b1;
    repeat (2) tick();
    check("cap_pending_early", 64'(irq_pending), 64'h00);
    tick();
    check("cap_pending", 64'(irq_pending), 64'h08);
    check("cap_irq_out_early", 64'(irq_out), 64'h0);
    tick();
    check("cap_irq_out", 64'(irq_out), 64'h1);
    host_sel = 4'd3;
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check("cap_rvalid", 64'(host_rvalid), 64'h1);
    check("cap_rdata", host_rdata, 64'h0123_4567_89AB_CDEF);
    check("cap_pending_clr", 64'(irq_pending), 64'h00);
    tick();
    check("cap_rvalid_drop", 64'(host_rvalid), 64'h0);
    check("cap_rdata_hold", host_rdata, 64'h0123_4567_89AB_CDEF);
    check("cap_irq_out_clr", 64'(irq_out), 64'h0);
    irq_joystick_export[3] = 1'b0;
    repeat (2) tick();

    // Overrun on channel 0
    pulse(0, 64'h11);
    check("ovr_none_yet", 64'(irq_overrun), 64'h00);
    pulse(0, 64'h22);
    check("ovr_set", 64'(irq_overrun), 64'h01);
    host_sel = 4'd0;
    tick();
    check("ovr_count", 64'(host_count), 64'h2);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check("ovr_rdata", host_rdata, 64'h22);
    host_clr_ovr = 1'b1;
    tick();
    host_clr_ovr = 1'b0;
    check("ovr_clr", 64'(irq_overrun), 64'h00);

    // Saturation of a 4-bit counter on channel 1, then clear with coincident edge
    for (int i = 0; i < 17; i++) pulse(1, 64'(i));
    host_sel = 4'd1;
    tick();
    check("sat_count", 64'(host_count), 64'hF);
    irq_joystick_export[1] = 1'b1;
    repeat (2) tick();
    reset_pulsecounter_export = 1'b1;
    tick();
    reset_pulsecounter_export = 1'b0;
    tick();
    check("clr_edge_count", 64'(host_count), 64'h1);
    irq_joystick_export[1] = 1'b0;
    repeat (2) tick();
    host_sel = 4'd0;
    tick();
    check("clr_other_count", 64'(host_count), 64'h0);

    // Write strobe, then out-of-range select
    host_sel = 4'd5;
    host_wdata = 64'hAA;
    host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
    check("wr_strobe", 64'(we_joystick_export), 64'h20);
    check("wr_data", we_joystick_data, 64'hAA);
    tick();
    check("wr_strobe_drop", 64'(we_joystick_export), 64'h00);
    check("wr_data_hold", we_joystick_data, 64'hAA);
    host_sel = 4'd9;
    host_wdata = 64'h55;
    host_wr = 1'b1;
    tick();
    host_wr = 1'b0;
    check("oor_no_strobe", 64'(we_joystick_export), 64'h00);
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check("oor_rvalid", 64'(host_rvalid), 64'h1);
    check("oor_rdata", host_rdata, 64'h0);
    check("oor_count", 64'(host_count), 64'h0);

    // Read and edge on the same channel in the same cycle
    pulse(4, 64'h44);
    rd_joystick_data[4*DATA_W +: DATA_W] = 64'h55;
    irq_joystick_export[4] = 1'b1;
    repeat (2) tick();
    host_sel = 4'd4;
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    irq_joystick_export[4] = 1'b0;
    check("coin_rdata_old", host_rdata, 64'h44);
    check("coin_pending", 64'(irq_pending[4]), 64'h1);
    check("coin_overrun", 64'(irq_overrun[4]), 64'h1);
    repeat (2) tick();
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check("coin_rdata_new", host_rdata, 64'h55);
    check("coin_pending_clr", 64'(irq_pending[4]), 64'h0);

    // Timestamp of a capture on channel 2
    ts_base = cyc;
    rd_joystick_data[2*DATA_W +: DATA_W] = 64'h2;
    irq_joystick_export[2] = 1'b1;
    repeat (3) tick();
    irq_joystick_export[2] = 1'b0;
    repeat (2) tick();
    host_sel = 4'd2;
    host_rd = 1'b1;
    tick();
    host_rd = 1'b0;
    check("ts_rdata", host_rdata, 64'h2);
`ifdef JOYHUB_TIMESTAMP_EN
    check("ts_rts", 64'(host_rts), 64'(ts_base + 2));
`else
    check("ts_rts", 64'(host_rts), 64'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
